// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, byte/half/word
// lane-merged stores, extended loads, one-cycle MemReady. Option macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [1:0]      sz_q, sz_d;
  logic            uns_q, uns_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  // Address bits above the array size only wrap.
  logic            unused_addr_hi;
  assign unused_addr_hi = &{1'b0, Addr[31:AW+2]};

  // Request fields seen by the load/error path: live inputs when responding straight from IDLE.
  logic            cur_wr_c;
  logic [1:0]      cur_sz_c;
  logic            cur_uns_c;
  logic [AW+1:0]   cur_addr_c;
  logic [31:0]     cur_word_c;
  logic [7:0]      cur_byte_c;
  logic [15:0]     cur_half_c;
  logic [31:0]     load_val_c;
  logic            acc_err_c;
  logic            load_now_c;

  always_comb begin
    if (state_q == S_IDLE) begin
      cur_wr_c   = MemWrite;
      cur_sz_c   = Size;
      cur_uns_c  = Unsigned;
      cur_addr_c = Addr[AW+1:0];
    end else begin
      cur_wr_c   = wr_q;
      cur_sz_c   = sz_q;
      cur_uns_c  = uns_q;
      cur_addr_c = addr_q;
    end
    cur_word_c = mem[cur_addr_c[AW+1:2]];
    cur_byte_c = cur_word_c[8*cur_addr_c[1:0] +: 8];
    cur_half_c = cur_addr_c[1] ? cur_word_c[31:16] : cur_word_c[15:0];
    acc_err_c  = (cur_sz_c == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((cur_sz_c == 2'b01) && cur_addr_c[0])
      acc_err_c = 1'b1;
    if ((cur_sz_c == 2'b10) && (cur_addr_c[1:0] != 2'b00))
      acc_err_c = 1'b1;
`endif
    case (cur_sz_c)
      2'b00:   load_val_c = cur_uns_c ? {24'd0, cur_byte_c}
                                      : {{24{cur_byte_c[7]}}, cur_byte_c};
      2'b01:   load_val_c = cur_uns_c ? {16'd0, cur_half_c}
                                      : {{16{cur_half_c[15]}}, cur_half_c};
      default: load_val_c = cur_word_c;
    endcase
  end

  // Next-state and registered output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    sz_d       = sz_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'd0;
    load_now_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          wr_d    = MemWrite;
          sz_d    = Size;
          uns_d   = Unsigned;
          addr_d  = Addr[AW+1:0];
          wdata_d = WriteData;
          cnt_d   = CW'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_RESP;
            load_now_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d    = S_RESP;
          load_now_c = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_now_c) begin
      ready_d = 1'b1;
      err_d   = acc_err_c;
      rdata_d = (acc_err_c || cur_wr_c) ? 32'd0 : load_val_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sz_q    <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      sz_q    <= sz_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Store lane enables and lane-aligned data, committed at the edge ending RESP.
  logic        we_c;
  logic [3:0]  be_c;
  logic [31:0] wword_c;

  always_comb begin
    be_c    = 4'b0000;
    wword_c = 32'd0;
    case (sz_q)
      2'b00: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wword_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b1111;
        wword_c = wdata_q;
      end
      default: begin
        be_c    = 4'b0000;
        wword_c = 32'd0;
      end
    endcase
    we_c = (state_q == S_RESP) && wr_q && !err_q && !reset;
  end

  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i])
          mem[addr_q[AW+1:2]][8*i +: 8] <= wword_c[8*i +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule
